// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional statistics are enabled with the DM_ARB_STATS_EN macro.
package dm_arb_pkg;

  localparam int ARB_AW   = 8;
  localparam int ARB_DW   = 8;
  localparam int STARVE_W = 4;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    ARB_CORE_PRI   = 2'd0,
    ARB_HOST_FORCE = 2'd1,
    ARB_HOST_LOCK  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } mem_req_t;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dm_arb_stats.sv
// Saturating grant and conflict counters for the data-memory arbiter.
// Only instantiated when DM_ARB_STATS_EN is defined.
module dm_arb_stats
  import dm_arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             core_gnt_i,
  input  logic             host_gnt_i,
  input  logic             conflict_i,
  output logic [CNT_W-1:0] core_gnt_cnt_o,
  output logic [CNT_W-1:0] host_gnt_cnt_o,
  output logic [CNT_W-1:0] conflict_cnt_o
);

  logic [CNT_W-1:0] coreCnt_q, coreCnt_d;
  logic [CNT_W-1:0] hostCnt_q, hostCnt_d;
  logic [CNT_W-1:0] conflictCnt_q, conflictCnt_d;

  always_comb begin
    coreCnt_d     = core_gnt_i ? satInc(coreCnt_q) : coreCnt_q;
    hostCnt_d     = host_gnt_i ? satInc(hostCnt_q) : hostCnt_q;
    conflictCnt_d = conflict_i ? satInc(conflictCnt_q) : conflictCnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coreCnt_q     <= '0;
      hostCnt_q     <= '0;
      conflictCnt_q <= '0;
    end else begin
      coreCnt_q     <= coreCnt_d;
      hostCnt_q     <= hostCnt_d;
      conflictCnt_q <= conflictCnt_d;
    end
  end

  assign core_gnt_cnt_o = coreCnt_q;
  assign host_gnt_cnt_o = hostCnt_q;
  assign conflict_cnt_o = conflictCnt_q;

endmodule

// File: rtl/dm_arbiter.sv
// Core/host arbiter for the single-port data memory: core priority, bounded host
// starvation, host lock. DM_ARB_STATS_EN adds saturating grant/conflict counters.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW         = ARB_AW,
  parameter int DW         = ARB_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic          core_gnt_o,
  output logic          core_stall_o,
  output logic          core_rvalid_o,
  output logic [DW-1:0] core_rdata_o,
  input  logic          host_req_i,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [DW-1:0] host_wdata_i,
  input  logic          host_lock_i,
  output logic          host_gnt_o,
  output logic          host_rvalid_o,
  output logic [DW-1:0] host_rdata_o,
`ifdef DM_ARB_STATS_EN
  output logic [15:0]   core_gnt_cnt_o,
  output logic [15:0]   host_gnt_cnt_o,
  output logic [15:0]   conflict_cnt_o,
`endif
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : gBadStarve
    $error("dm_arbiter: STARVE_MAX must be within 1..15");
  end
  if (AW != ARB_AW || DW != ARB_DW) begin : gBadWidth
    $error("dm_arbiter: AW/DW must match the package memory request widths");
  end

  localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                coreGnt, hostGnt;
  mem_req_t            memReq;
  logic                coreRvalid_q, hostRvalid_q;
  logic [DW-1:0]       coreRdata_q, hostRdata_q;

  // Grants are suppressed while reset is asserted so nothing reaches memory.
  always_comb begin
    coreGnt = 1'b0;
    hostGnt = 1'b0;
    unique case (state_q)
      ARB_CORE_PRI: begin
        coreGnt = core_req_i;
        hostGnt = host_req_i & ~core_req_i;
      end
      ARB_HOST_FORCE, ARB_HOST_LOCK: hostGnt = host_req_i;
      default: ;
    endcase
    coreGnt = coreGnt & rst_ni;
    hostGnt = hostGnt & rst_ni;
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (hostGnt || !host_req_i) begin
      starve_d = '0;
    end else if (starve_q != {STARVE_W{1'b1}}) begin
      starve_d = starve_q + STARVE_W'(1);
    end
    // Forcing takes effect in the cycle right after the count reaches its limit.
    unique case (state_q)
      ARB_CORE_PRI: begin
        if (starve_d == StarveMax) begin
          state_d = ARB_HOST_FORCE;
        end else if (hostGnt && host_lock_i) begin
          state_d = ARB_HOST_LOCK;
        end
      end
      ARB_HOST_FORCE: state_d = host_lock_i ? ARB_HOST_LOCK : ARB_CORE_PRI;
      ARB_HOST_LOCK: begin
        if (!host_lock_i) begin
          state_d = ARB_CORE_PRI;
        end
      end
      default: state_d = ARB_CORE_PRI;
    endcase
  end

  always_comb begin
    memReq = '0;
    if (coreGnt) begin
      memReq.we    = core_we_i;
      memReq.addr  = core_addr_i;
      memReq.wdata = core_wdata_i;
    end else if (hostGnt) begin
      memReq.we    = host_we_i;
      memReq.addr  = host_addr_i;
      memReq.wdata = host_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB_CORE_PRI;
      starve_q     <= '0;
      coreRvalid_q <= 1'b0;
      hostRvalid_q <= 1'b0;
      coreRdata_q  <= '0;
      hostRdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      coreRvalid_q <= coreGnt & ~core_we_i;
      hostRvalid_q <= hostGnt & ~host_we_i;
      if (coreGnt && !core_we_i) begin
        coreRdata_q <= mem_rdata_i;
      end
      if (hostGnt && !host_we_i) begin
        hostRdata_q <= mem_rdata_i;
      end
    end
  end

  assign core_gnt_o    = coreGnt;
  assign core_stall_o  = rst_ni & core_req_i & ~coreGnt;
  assign core_rvalid_o = coreRvalid_q;
  assign core_rdata_o  = coreRdata_q;
  assign host_gnt_o    = hostGnt;
  assign host_rvalid_o = hostRvalid_q;
  assign host_rdata_o  = hostRdata_q;
  assign mem_addr_o    = memReq.addr;
  assign mem_we_o      = memReq.we;
  assign mem_wdata_o   = memReq.wdata;

`ifdef DM_ARB_STATS_EN
  dm_arb_stats uStats (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .core_gnt_i     (coreGnt),
    .host_gnt_i     (hostGnt),
    .conflict_i     (core_req_i & host_req_i),
    .core_gnt_cnt_o (core_gnt_cnt_o),
    .host_gnt_cnt_o (host_gnt_cnt_o),
    .conflict_cnt_o (conflict_cnt_o)
  );
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized self-checking bench for dm_arbiter against a cycle-level reference model.
// Statistics checks are compiled in when DM_ARB_STATS_EN is defined.
module tb_dm_arbiter;

  localparam int STARVE_MAX = 4;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       coreReq = 1'b0, coreWe = 1'b0, hostReq = 1'b0, hostWe = 1'b0, hostLock = 1'b0;
  logic [7:0] coreAddr = '0, coreWdata = '0, hostAddr = '0, hostWdata = '0;
  logic       coreGnt, coreStall, coreRvalid, hostGnt, hostRvalid, memWe;
  logic [7:0] coreRdata, hostRdata, memAddr, memWdata, memRdata;
`ifdef DM_ARB_STATS_EN
  logic [15:0] coreGntCnt, hostGntCnt, conflictCnt;
`endif

  logic [7:0] dm     [256];
  logic [7:0] refMem [256];

  int checks = 0;
  int errors = 0;

  // Reference model of the arbitration rules
  bit         modelLocked, modelForce;
  int         modelDenied;
  bit         expCoreRvalid, expHostRvalid;
  logic [7:0] expCoreRdata, expHostRdata;
  logic       lastCoreGnt, lastHostGnt, lastCoreStall, lastCoreRvalid;

  always #5 clk = ~clk;

  assign memRdata = dm[memAddr];
  always @(posedge clk) if (memWe) dm[memAddr] <= memWdata;

  dm_arbiter #(.AW(8), .DW(8), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .core_req_i    (coreReq),
    .core_we_i     (coreWe),
    .core_addr_i   (coreAddr),
    .core_wdata_i  (coreWdata),
    .core_gnt_o    (coreGnt),
    .core_stall_o  (coreStall),
    .core_rvalid_o (coreRvalid),
    .core_rdata_o  (coreRdata),
    .host_req_i    (hostReq),
    .host_we_i     (hostWe),
    .host_addr_i   (hostAddr),
    .host_wdata_i  (hostWdata),
    .host_lock_i   (hostLock),
    .host_gnt_o    (hostGnt),
    .host_rvalid_o (hostRvalid),
    .host_rdata_o  (hostRdata),
`ifdef DM_ARB_STATS_EN
    .core_gnt_cnt_o (coreGntCnt),
    .host_gnt_cnt_o (hostGntCnt),
    .conflict_cnt_o (conflictCnt),
`endif
    .mem_addr_o    (memAddr),
    .mem_we_o      (memWe),
    .mem_wdata_o   (memWdata),
    .mem_rdata_i   (memRdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    modelLocked   = 0;
    modelForce    = 0;
    modelDenied   = 0;
    expCoreRvalid = 0;
    expHostRvalid = 0;
    expCoreRdata  = '0;
    expHostRdata  = '0;
  endtask

  // Called at a falling edge: reset asserts mid-cycle, outputs must clear at once.
  task automatic applyReset();
    #1 rstN = 1'b0;
    #1;
    checkOutput("rst_core_gnt", coreGnt, 0);
    checkOutput("rst_host_gnt", hostGnt, 0);
    checkOutput("rst_core_stall", coreStall, 0);
    checkOutput("rst_core_rvalid", coreRvalid, 0);
    checkOutput("rst_host_rvalid", hostRvalid, 0);
    checkOutput("rst_core_rdata", coreRdata, 0);
    checkOutput("rst_host_rdata", hostRdata, 0);
    checkOutput("rst_mem_we", memWe, 0);
    checkOutput("rst_mem_addr", memAddr, 0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    resetModel();
  endtask

  // One clock cycle with inputs already driven; checks everything against the model.
  task automatic applyStimulus();
    bit         eCore, eHost;
    logic       eWe;
    logic [7:0] eAddr;
    #1;
    if (modelForce || modelLocked) begin
      eCore = 0;
      eHost = hostReq;
    end else begin
      eCore = coreReq;
      eHost = hostReq && !coreReq;
    end
    eWe   = eCore ? coreWe : (eHost ? hostWe : 1'b0);
    eAddr = eCore ? coreAddr : (eHost ? hostAddr : 8'h00);
    checkOutput("core_gnt", coreGnt, eCore);
    checkOutput("host_gnt", hostGnt, eHost);
    checkOutput("core_stall", coreStall, coreReq && !eCore);
    checkOutput("mem_we", memWe, eWe);
    checkOutput("mem_addr", memAddr, eAddr);
    if (eWe) checkOutput("mem_wdata", memWdata, eCore ? coreWdata : hostWdata);
    checkOutput("core_rvalid", coreRvalid, expCoreRvalid);
    checkOutput("core_rdata", coreRdata, expCoreRdata);
    checkOutput("host_rvalid", hostRvalid, expHostRvalid);
    checkOutput("host_rdata", hostRdata, expHostRdata);
    lastCoreGnt    = coreGnt;
    lastHostGnt    = hostGnt;
    lastCoreStall  = coreStall;
    lastCoreRvalid = coreRvalid;
    @(posedge clk);
    expCoreRvalid = eCore && !coreWe;
    expHostRvalid = eHost && !hostWe;
    if (expCoreRvalid) expCoreRdata = refMem[coreAddr];
    if (expHostRvalid) expHostRdata = refMem[hostAddr];
    if (eCore && coreWe) refMem[coreAddr] = coreWdata;
    if (eHost && hostWe) refMem[hostAddr] = hostWdata;
    modelDenied = (hostReq && !eHost) ? modelDenied + 1 : 0;
    if (modelForce) begin
      modelForce  = 0;
      modelLocked = hostLock;
    end else if (modelLocked) begin
      modelLocked = hostLock;
    end else if (modelDenied == STARVE_MAX) begin
      modelForce = 1;
    end else if (eHost && hostLock) begin
      modelLocked = 1;
    end
    @(negedge clk);
    if (eCore) coreReq = 1'b0;
    if (eHost) hostReq = 1'b0;
  endtask

  task automatic setCore(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    coreReq = 1'b1; coreWe = we; coreAddr = addr; coreWdata = wdata;
  endtask

  task automatic setHost(input logic we, input logic [7:0] addr, input logic [7:0] wdata, input logic lock);
    hostReq = 1'b1; hostWe = we; hostAddr = addr; hostWdata = wdata; hostLock = lock;
  endtask

  initial begin
    int cyc;
    int coreInLock;
    for (int i = 0; i < 256; i++) begin
      dm[i]     = 8'($urandom_range(0, 255));
      refMem[i] = dm[i];
    end
    resetModel();
    @(negedge clk);
    applyReset();

    // Core-only read
    dm[60] = 8'd240; refMem[60] = 8'd240;
    setCore(1'b0, 8'd60, 8'd0);
    applyStimulus();
    checkOutput("t1_core_gnt", lastCoreGnt, 1);
    applyStimulus();
    checkOutput("t1_core_rvalid", lastCoreRvalid, 1);
    checkOutput("t1_core_rdata", coreRdata, 240);

    // Contention: host forced through after STARVE_MAX denied cycles
    applyReset();
    setHost(1'b1, 8'd0, 8'd85, 1'b0);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (!coreReq) setCore(1'b0, 8'($urandom_range(16, 31)), 8'd0);
      applyStimulus();
      cyc++;
      if (lastHostGnt) break;
    end
    checkOutput("t2_host_cycle", cyc, 5);
    checkOutput("t2_core_gnt", lastCoreGnt, 0);
    checkOutput("t2_core_stall", lastCoreStall, 1);
    checkOutput("t2_dm0", dm[0], 85);

    // Host lock: four writes, core blocked until lock drops
    applyReset();
    coreReq = 1'b0;
    coreInLock = 0;
    setHost(1'b1, 8'd5, 8'hA5, 1'b1);
    applyStimulus();
    setCore(1'b0, 8'd5, 8'd0);
    for (int a = 6; a <= 8; a++) begin
      setHost(1'b1, 8'(a), 8'(a + 8'hA0), 1'b1);
      applyStimulus();
      coreInLock += int'(lastCoreGnt);
    end
    hostReq = 1'b0; hostLock = 1'b0;
    applyStimulus();
    coreInLock += int'(lastCoreGnt);
    checkOutput("t3_core_in_lock", coreInLock, 0);
    applyStimulus();
    checkOutput("t3_core_after_unlock", lastCoreGnt, 1);
    checkOutput("t3_dm5", dm[5], 8'hA5);
    checkOutput("t3_dm8", dm[8], 8'hA8);

    // Reset while locked with a host read in flight
    coreReq = 1'b0;
    setHost(1'b0, 8'd9, 8'd0, 1'b1);
    applyStimulus();
    setHost(1'b0, 8'd10, 8'd0, 1'b1);
    setCore(1'b0, 8'd11, 8'd0);
    applyReset();
    applyStimulus();
    checkOutput("t4_core_first", lastCoreGnt, 1);
    hostLock = 1'b0;
    applyStimulus();

    // Same-address core read and host write: core reads old data first
    applyReset();
    dm[61] = 8'h2A; refMem[61] = 8'h2A;
    setCore(1'b0, 8'd61, 8'd0);
    setHost(1'b1, 8'd61, 8'd7, 1'b0);
    applyStimulus();
    applyStimulus();
    checkOutput("t5_core_old", coreRdata, 8'h2A);
    checkOutput("t5_dm61", dm[61], 7);

`ifdef DM_ARB_STATS_EN
    applyReset();
    for (int i = 0; i < 10; i++) begin
      if (!coreReq) setCore(1'b0, 8'($urandom_range(0, 15)), 8'd0);
      if (!hostReq) setHost(1'b0, 8'($urandom_range(0, 15)), 8'd0, 1'b0);
      applyStimulus();
    end
    checkOutput("t6_conflict_cnt", conflictCnt, 10);
    checkOutput("t6_host_gnt_cnt", hostGntCnt, 2);
    checkOutput("t6_core_gnt_cnt", coreGntCnt, 8);
    coreReq = 1'b0; hostReq = 1'b0;
`endif

    // Randomized traffic on a small address window to provoke collisions
    applyReset();
    for (int n = 0; n < 3000; n++) begin
      if (!coreReq && $urandom_range(0, 2) == 0)
        setCore(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      if (!hostReq && $urandom_range(0, 4) == 0)
        setHost(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), hostLock);
      if ($urandom_range(0, 7) == 0) hostLock = ~hostLock;
      if ($urandom_range(0, 499) == 0) applyReset();
      else applyStimulus();
    end
    for (int i = 0; i < 16; i++) checkOutput("final_mem", dm[i], refMem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
